// File: rtl/truth_check_pkg.sv
// Shared constants for the truth-table checker: FSM state encoding and
// default sweep parameters.
package truth_check_pkg;

    // Default sweep geometry
    localparam int unsigned N_IN_DEF   = 3;
    localparam int unsigned SETTLE_DEF = 2;
    localparam int unsigned ERR_W_DEF  = 4;

    // FSM state encoding
    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_WAIT = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE = 2'd2;

endpackage : truth_check_pkg

// File: rtl/settle_timer.sv
// Loadable down-counter that times how long each vector is held before it
// is sampled. Reloads to SETTLE-1 on load, counts down while enabled and
// stops at zero.
//   clk, rst_n : clock, async active-low reset (counter clears to 0)
//   load       : reload the counter with SETTLE-1 (has priority over en)
//   en         : decrement while non-zero
//   zero_c     : counter is zero (combinational from the counter register)
module settle_timer #(
    parameter int unsigned SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero_c
);

    localparam int unsigned         CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0]    LOAD_VAL = CNT_W'(SETTLE - 1);

    logic [CNT_W-1:0] cnt;

    // Down-counter with synchronous load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule : settle_timer

// File: rtl/truth_table_checker.sv
// Sweeps every N_IN-bit input combination onto a shared vector bus feeding a
// "question" and an "answer" combinational block, holds each vector for
// SETTLE cycles, then compares the two results and accumulates a saturating
// mismatch count, the first failing vector and an overall pass flag.
//   clk, rst_n      : clock, async active-low reset
//   start           : begin a sweep (honoured only in IDLE or DONE)
//   vec             : vector driven to both blocks (MSB = first input)
//   m_q, m_a        : question / answer block outputs
//   busy            : sweep in progress
//   done            : sweep complete, held until next start or reset
//   pass            : done with zero mismatches (combinational)
//   err_count       : saturating mismatch count
//   first_err_vec   : vector of the first mismatch
//   first_err_valid : first_err_vec holds a captured value
module truth_table_checker
    import truth_check_pkg::*;
#(
    parameter int unsigned N_IN   = N_IN_DEF,
    parameter int unsigned SETTLE = SETTLE_DEF,
    parameter int unsigned ERR_W  = ERR_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N_IN-1:0]  vec,
    input  logic             m_q,
    input  logic             m_a,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [N_IN-1:0]  first_err_vec,
    output logic             first_err_valid
);

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    logic [ST_W-1:0]  state;
    logic [ST_W-1:0]  state_nxt;

    logic [N_IN-1:0]  vec_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic [ERR_W-1:0] err_count_nxt;
    logic [N_IN-1:0]  first_err_vec_nxt;
    logic             first_err_valid_nxt;

    logic start_acc_c;
    logic sample_c;
    logic vec_last_c;
    logic mismatch_c;
    logic tmr_zero_c;
    logic tmr_load_c;
    logic tmr_en_c;

    // Qualifiers: start is only honoured outside a sweep; the sample edge is
    // the WAIT cycle where the settle timer has reached zero.
    assign start_acc_c = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign sample_c    = (state == ST_WAIT) && tmr_zero_c;
    assign vec_last_c  = &vec;
    assign mismatch_c  = (m_q != m_a);

    // Reload on a new sweep and on every vector advance; the last vector
    // needs no reload because the sweep ends there.
    assign tmr_load_c = start_acc_c || (sample_c && !vec_last_c);
    assign tmr_en_c   = (state == ST_WAIT);

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load_c),
        .en     (tmr_en_c),
        .zero_c (tmr_zero_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)                 state_nxt = ST_WAIT;
            ST_WAIT: if (sample_c && vec_last_c) state_nxt = ST_DONE;
            ST_DONE: if (start)                 state_nxt = ST_WAIT;
            default:                            state_nxt = ST_IDLE;
        endcase
    end

    // Output / datapath next values; everything holds unless updated below
    always_comb begin
        vec_nxt             = vec;
        busy_nxt            = busy;
        done_nxt            = done;
        err_count_nxt       = err_count;
        first_err_vec_nxt   = first_err_vec;
        first_err_valid_nxt = first_err_valid;

        if (start_acc_c) begin
            // New sweep clears the previous results in the same edge
            vec_nxt             = '0;
            busy_nxt            = 1'b1;
            done_nxt            = 1'b0;
            err_count_nxt       = '0;
            first_err_vec_nxt   = '0;
            first_err_valid_nxt = 1'b0;
        end else if (sample_c) begin
            if (mismatch_c) begin
                if (err_count != ERR_MAX) begin
                    err_count_nxt = err_count + ERR_W'(1);
                end
                if (!first_err_valid) begin
                    first_err_vec_nxt   = vec;
                    first_err_valid_nxt = 1'b1;
                end
            end
            if (vec_last_c) begin
                // Vector stays all-ones once the sweep completes
                busy_nxt = 1'b0;
                done_nxt = 1'b1;
            end else begin
                vec_nxt = vec + N_IN'(1);
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec             <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            vec             <= vec_nxt;
            busy            <= busy_nxt;
            done            <= done_nxt;
            err_count       <= err_count_nxt;
            first_err_vec   <= first_err_vec_nxt;
            first_err_valid <= first_err_valid_nxt;
        end
    end

    // Only meaningful once a sweep has finished
    assign pass = done && (err_count == '0);

endmodule : truth_table_checker

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: question/answer blocks are modelled as
// truth tables indexed by the DUT's vector; each sweep's expected result is
// queued at start and checked by a monitor when done rises.
module tb_truth_table_checker;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] vec;
    logic       m_q, m_a;
    logic       busy, done, pass;
    logic [3:0] err_count;
    logic [2:0] first_err_vec;
    logic       first_err_valid;

    logic [7:0] tt_a = 8'h00;
    logic [7:0] tt_q = 8'h00;

    // Second instance: wide sweep, every vector mismatching, to saturate
    logic       start2 = 1'b0;
    logic [4:0] vec2;
    logic       m_q2 = 1'b1;
    logic       m_a2 = 1'b0;
    logic       busy2, done2, pass2;
    logic [3:0] err_count2;
    logic [4:0] first_err_vec2;
    logic       first_err_valid2;

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc   = 0;

    typedef struct {
        logic [3:0]  err;
        logic [2:0]  fev;
        logic        fevalid;
        logic        pass;
        int unsigned done_cyc;
    } exp_t;

    exp_t exp_q[$];

    assign m_a = tt_a[vec];
    assign m_q = tt_q[vec];

    truth_table_checker #(.N_IN(3), .SETTLE(2), .ERR_W(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .vec             (vec),
        .m_q             (m_q),
        .m_a             (m_a),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_err_vec   (first_err_vec),
        .first_err_valid (first_err_valid)
    );

    truth_table_checker #(.N_IN(5), .SETTLE(1), .ERR_W(4)) dut2 (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start2),
        .vec             (vec2),
        .m_q             (m_q2),
        .m_a             (m_a2),
        .busy            (busy2),
        .done            (done2),
        .pass            (pass2),
        .err_count       (err_count2),
        .first_err_vec   (first_err_vec2),
        .first_err_valid (first_err_valid2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: count differing table entries, lowest differing index first
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] q, input int unsigned dc);
        exp_t e;
        int   n = 0;
        e.fev     = 3'd0;
        e.fevalid = 1'b0;
        for (int v = 0; v < 8; v++) begin
            if (a[v] != q[v]) begin
                if (!e.fevalid) begin
                    e.fev     = 3'(v);
                    e.fevalid = 1'b1;
                end
                n++;
            end
        end
        e.err      = (n > 15) ? 4'd15 : 4'(n);
        e.pass     = (n == 0);
        e.done_cyc = dc;
        return e;
    endfunction

    // Monitor: on each rising done, pop and compare the expected result
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            done_prev = 1'b0;
        end else begin
            if (busy) check("pass_while_busy", 32'(pass), 32'd0);
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("err_count",       32'(err_count),       32'(e.err));
                    check("first_err_vec",   32'(first_err_vec),   32'(e.fev));
                    check("first_err_valid", 32'(first_err_valid), 32'(e.fevalid));
                    check("pass",            32'(pass),            32'(e.pass));
                    check("final_vec",       32'(vec),             32'd7);
                    check("busy_at_done",    32'(busy),            32'd0);
                    check("done_cycle",      cyc,                  e.done_cyc);
                end
            end
            done_prev = done;
        end
    end

    task automatic wait_vec(input logic [2:0] target);
        bit hit = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (vec == target) begin
                hit = 1;
                break;
            end
        end
        if (!hit) check("wait_vec_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        bit hit = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                hit = 1;
                break;
            end
        end
        if (!hit) check("done_timeout", 32'd0, 32'd1);
    endtask

    // Launch one sweep; optionally re-pulse start mid-sweep (must be ignored)
    task automatic run_sweep(input logic [7:0] a, input logic [7:0] q, input bit restart_at3);
        tt_a = a;
        tt_q = q;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        exp_q.push_back(model(a, q, cyc + 16));
        check("start_busy",   32'(busy),            32'd1);
        check("start_done",   32'(done),            32'd0);
        check("start_err",    32'(err_count),       32'd0);
        check("start_fvalid", 32'(first_err_valid), 32'd0);
        check("start_vec",    32'(vec),             32'd0);
        if (restart_at3) begin
            wait_vec(3'd3);
            start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        wait_done();
    endtask

    initial begin
        logic [7:0] a, q;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_vec",    32'(vec),             32'd0);
        check("rst_busy",   32'(busy),            32'd0);
        check("rst_done",   32'(done),            32'd0);
        check("rst_pass",   32'(pass),            32'd0);
        check("rst_err",    32'(err_count),       32'd0);
        check("rst_fev",    32'(first_err_vec),   32'd0);
        check("rst_fvalid", 32'(first_err_valid), 32'd0);
        rst_n = 1'b1;

        // Directed sweeps: clean majority, inverted, single fault at 5,
        // then an ignored mid-sweep start (also a restart from DONE)
        run_sweep(8'hE8, 8'hE8, 0);
        run_sweep(8'hE8, 8'h17, 0);
        run_sweep(8'hE8, 8'hC8, 0);
        run_sweep(8'hE8, 8'hE8 ^ 8'h0A, 1);

        // Randomised tables, some identical
        for (int i = 0; i < 10; i++) begin
            a = 8'($urandom);
            q = ($urandom_range(0, 2) == 0) ? a : (a ^ 8'($urandom));
            run_sweep(a, q, ($urandom_range(0, 3) == 0));
        end

        // Mid-sweep reset aborts asynchronously with nothing retained
        tt_a = 8'hE8;
        tt_q = 8'h17;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        exp_q.push_back(model(8'hE8, 8'h17, cyc + 16));
        wait_vec(3'd4);
        check("pre_rst_err", 32'(err_count), 32'd4);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy),      32'd0);
        check("midrst_vec",  32'(vec),       32'd0);
        check("midrst_err",  32'(err_count), 32'd0);
        check("midrst_done", 32'(done),      32'd0);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        run_sweep(8'h96, 8'h97, 0);

        // Saturation on the wide instance, then restart from DONE
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        begin
            bit hit = 0;
            for (int i = 0; i < 80; i++) begin
                @(negedge clk);
                if (done2) begin
                    hit = 1;
                    break;
                end
            end
            if (!hit) check("done2_timeout", 32'd0, 32'd1);
        end
        check("sat_err",    32'(err_count2),       32'd15);
        check("sat_fev",    32'(first_err_vec2),   32'd0);
        check("sat_fvalid", 32'(first_err_valid2), 32'd1);
        check("sat_pass",   32'(pass2),            32'd0);
        check("sat_vec",    32'(vec2),             32'd31);
        start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        check("restart_err",  32'(err_count2), 32'd0);
        check("restart_done", 32'(done2),      32'd0);
        check("restart_busy", 32'(busy2),      32'd1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_truth_table_checker

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
Sequential stimulus-and-check stage wrapped around a pair of combinational logic blocks: a student "question" implementation and a reference "answer" implementation.
- Sweeps every input combination onto a shared vector bus that feeds both blocks.
- Waits a programmable settle time, then compares the two single-bit results.
- Reports mismatch count, first failing vector and overall pass/fail.
- Replaces hand-written timed initial-block stimulus with a synthesizable, self-checking sweep.

Parameters:
- N_IN, 3, number of DUT inputs; sweep covers 2^N_IN vectors.
- SETTLE, 2, clock cycles each vector is held before sampling; legal range ≥1.
- ERR_W, 4, width of the mismatch counter; counter saturates.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- vec  out  N_IN  input vector driven to both DUTs; bit N_IN-1 = a, …, bit 0 = c for N_IN=3.
- m_q  in  1  output of the question block.
- m_a  in  1  output of the answer block.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; held until next start or reset.
- pass  out  1  done && err_count==0.
- err_count  out  ERR_W  number of mismatching vectors, saturating at 2^ERR_W-1.
- first_err_vec  out  N_IN  vector of the first mismatch.
- first_err_valid  out  1  first_err_vec holds a captured value.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - vec=0, busy=0, done=0, pass=0, err_count=0, first_err_vec=0, first_err_valid=0.
  - Settle counter = 0.
  - Reset asserted mid-sweep aborts immediately; no partial result is retained.
- States: IDLE, WAIT, DONE.
- IDLE → WAIT on start=1:
  - vec←0, err_count←0, first_err_valid←0, first_err_vec←0.
  - cnt←SETTLE-1, busy←1, done←0.
- WAIT, cnt≠0: cnt←cnt-1; vec held.
- WAIT, cnt==0 (sample edge): compare m_q against m_a.
  - On mismatch: err_count←err_count+1 unless saturated.
  - On mismatch with first_err_valid==0: first_err_vec←vec, first_err_valid←1.
  - If vec is all-ones: go to DONE, busy←0, done←1. vec stays all-ones.
  - Otherwise: vec←vec+1, cnt←SETTLE-1. No wrap occurs inside a sweep.
- Timing: the sample edge for a vector is SETTLE edges after that vector is first driven. done rises 2^N_IN·SETTLE edges after the start edge; N_IN=3, SETTLE=2 gives 16.
- DONE: all results held stable. start=1 restarts exactly as from IDLE and clears the previous results in the same edge.
- start while busy (WAIT) is ignored; the sweep is not restarted.
- pass is combinational from the done and err_count registers and is never 1 while busy.
- m_q and m_a are sampled only at sample edges; values at other cycles are don't-care.
- X on m_q/m_a at a sample edge counts as a mismatch (checker treats !== semantics in verification only; RTL uses !=).

Decomposition:
- Shared package truth_check_pkg holds:
  - state encoding constants ST_IDLE, ST_WAIT, ST_DONE (2 bits);
  - default values of N_IN, SETTLE, ERR_W.
- One sub-module is natural: settle_timer. It is a loadable down-counter with load, load value SETTLE-1 and a zero flag; it generates the sample strobe.
- Vector counter, error counter and FSM live in the top module.

Test Plan:
- Clean run: m_q and m_a both driven by the 3-input majority function; start pulse → busy for 16 cycles, then done=1, pass=1, err_count=0, first_err_valid=0, vec=7.
- Inverted m_q: m_q=~m_a → err_count=8, first_err_vec=0, first_err_valid=1, pass=0.
- Single fault: m_q differs from m_a only at vec=5 → err_count=1, first_err_vec=5.
- Ignored start: start re-pulsed while vec=3 → sweep continues; done still arrives at cycle 16 after the original start.
- Mid-sweep reset: rst_n low at vec=4 → busy=0, vec=0 and err_count=0 immediately, without waiting for a clock edge. A subsequent start runs a full sweep.
- Saturation and restart: N_IN=5, ERR_W=4, all vectors mismatch → err_count=15 (saturated). A start issued in DONE clears err_count to 0 and done to 0 on the same edge.
